alarm_chime_controller: RTL and testbench

Sequential consumer of the car alarm's `CarAlarmSignal` output: debounces the level alarm request and converts it into a timed, countable buzzer pattern with a driver mute input. Sits downstream of the behavioral/structural alarm pair in the Car_Alarm design. It is exercised by a tester that drives `CarAlarmSignal` and `MuteButton` and monitors the buzzer outputs.

---
 rtl/alarm_chime_controller.sv | 152 +++++++++++++++
 tb/tb_alarm_chime_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_chime_controller.sv
// alarm_chime_controller: debounces the level alarm request and turns it into
// a timed, countable buzzer pattern with a driver mute and auto-mute after
// MAX_BEEPS completed beeps.
module alarm_chime_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned ON_CYCLES       = 3,
  parameter int unsigned OFF_CYCLES      = 2,
  parameter int unsigned MAX_BEEPS       = 5
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       CarAlarmSignal,
  input  logic       MuteButton,
  output logic       BuzzerOut,
  output logic       ChimeActive,
  output logic       Muted,
  output logic [3:0] BeepCount
);

  localparam int unsigned CW = 4;

  // Terminal values: a phase ends on the edge where its counter sits at N-1.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] BEEP_MAX = CW'(MAX_BEEPS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BEEP_ON  = 2'd1,
    BEEP_OFF = 2'd2,
    MUTED    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] deb_nx;
  logic [CW-1:0] tmr;
  logic [CW-1:0] tmr_nx;
  logic [CW-1:0] beeps_nx;
  logic [CW-1:0] beeps_inc_c;

  // Saturating increment of the completed-beep count.
  always_comb begin
    beeps_inc_c = BeepCount;
    if (BeepCount < BEEP_MAX) begin
      beeps_inc_c = BeepCount + CW'(1);
    end
  end

  // Next-state, timer, debounce and beep-count decode.
  always_comb begin
    state_nx = state;
    deb_nx   = deb_cnt;
    tmr_nx   = tmr;
    beeps_nx = BeepCount;

    case (state)
      IDLE: begin
        tmr_nx   = '0;
        beeps_nx = '0;
        if (CarAlarmSignal) begin
          if (deb_cnt >= DEB_LAST) begin
            state_nx = BEEP_ON;
            deb_nx   = '0;
          end else begin
            deb_nx = deb_cnt + CW'(1);
          end
        end else begin
          deb_nx = '0;
        end
      end

      BEEP_ON: begin
        deb_nx = '0;
        if (MuteButton) begin
          // Interrupted beep is not counted.
          state_nx = MUTED;
          tmr_nx   = '0;
        end else if (tmr >= ON_LAST) begin
          tmr_nx   = '0;
          beeps_nx = beeps_inc_c;
          if (beeps_inc_c == BEEP_MAX) begin
            state_nx = MUTED;
          end else begin
            state_nx = BEEP_OFF;
          end
        end else begin
          tmr_nx = tmr + CW'(1);
        end
      end

      BEEP_OFF: begin
        deb_nx = '0;
        if (MuteButton) begin
          state_nx = MUTED;
          tmr_nx   = '0;
        end else if (tmr >= OFF_LAST) begin
          tmr_nx = '0;
          // Alarm level sampled on the expiry edge decides; no re-debounce.
          if (CarAlarmSignal) begin
            state_nx = BEEP_ON;
          end else begin
            state_nx = IDLE;
            beeps_nx = '0;
          end
        end else begin
          tmr_nx = tmr + CW'(1);
        end
      end

      MUTED: begin
        deb_nx = '0;
        tmr_nx = '0;
        if (!CarAlarmSignal) begin
          state_nx = IDLE;
          beeps_nx = '0;
        end
      end

      default: begin
        state_nx = IDLE;
        deb_nx   = '0;
        tmr_nx   = '0;
        beeps_nx = '0;
      end
    endcase
  end

  // State, counters and outputs; outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      deb_cnt     <= '0;
      tmr         <= '0;
      BeepCount   <= '0;
      BuzzerOut   <= 1'b0;
      ChimeActive <= 1'b0;
      Muted       <= 1'b0;
    end else begin
      state       <= state_nx;
      deb_cnt     <= deb_nx;
      tmr         <= tmr_nx;
      BeepCount   <= beeps_nx;
      BuzzerOut   <= (state_nx == BEEP_ON);
      ChimeActive <= (state_nx == BEEP_ON) || (state_nx == BEEP_OFF);
      Muted       <= (state_nx == MUTED);
    end
  end

endmodule

// File: tb/tb_alarm_chime_controller.sv
// Scoreboard bench for alarm_chime_controller: stimulus steps a behavioural
// model and queues expected outputs; a monitor compares after each edge.
module tb_alarm_chime_controller;

  localparam int DEB   = 4;
  localparam int ONC   = 3;
  localparam int OFFC  = 2;
  localparam int MAXB  = 5;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       CarAlarmSignal;
  logic       MuteButton;
  logic       BuzzerOut;
  logic       ChimeActive;
  logic       Muted;
  logic [3:0] BeepCount;

  alarm_chime_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .ON_CYCLES      (ONC),
    .OFF_CYCLES     (OFFC),
    .MAX_BEEPS      (MAXB)
  ) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .CarAlarmSignal(CarAlarmSignal),
    .MuteButton    (MuteButton),
    .BuzzerOut     (BuzzerOut),
    .ChimeActive   (ChimeActive),
    .Muted         (Muted),
    .BeepCount     (BeepCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int buzz;
    int active;
    int muted;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   bad    = 0;
  int   pushed = 0;
  int   popped = 0;

  // Behavioural model: "chiming" episode with a phase countdown.
  bit m_chiming;
  bit m_sounding;
  bit m_muted;
  int m_left;
  int m_run;
  int m_beeps;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_chiming  = 0;
    m_sounding = 0;
    m_muted    = 0;
    m_left     = 0;
    m_run      = 0;
    m_beeps    = 0;
  endtask

  task automatic model_step(input bit a, input bit m);
    if (m_muted) begin
      if (!a) begin
        m_muted = 0;
        m_beeps = 0;
        m_run   = 0;
      end
    end else if (m_chiming) begin
      if (m) begin
        m_chiming  = 0;
        m_sounding = 0;
        m_muted    = 1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (m_sounding) begin
            m_beeps++;
            if (m_beeps >= MAXB) begin
              m_beeps    = MAXB;
              m_chiming  = 0;
              m_sounding = 0;
              m_muted    = 1;
            end else begin
              m_sounding = 0;
              m_left     = OFFC;
            end
          end else if (a) begin
            m_sounding = 1;
            m_left     = ONC;
          end else begin
            m_chiming = 0;
            m_beeps   = 0;
            m_run     = 0;
          end
        end
      end
    end else begin
      m_run = a ? m_run + 1 : 0;
      if (m_run >= DEB) begin
        m_run      = 0;
        m_chiming  = 1;
        m_sounding = 1;
        m_left     = ONC;
      end
    end
  endtask

  // Drive n cycles of (alarm, mute) and queue the expected post-edge outputs.
  task automatic cyc(input bit a, input bit m, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      CarAlarmSignal = a;
      MuteButton     = m;
      model_step(a, m);
      e.buzz   = int'(m_sounding);
      e.active = int'(m_chiming);
      e.muted  = int'(m_muted);
      e.count  = m_beeps;
      exp_q.push_back(e);
      pushed++;
    end
  endtask

  // Wait until the last queued edge has been checked.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic reset_pulse();
    @(negedge clk);
    #2;
    reset_L        = 1'b0;
    CarAlarmSignal = 1'b0;
    MuteButton     = 1'b0;
    #1;
    chk("async_reset_buzzer", int'(BuzzerOut), 0);
    chk("async_reset_active", int'(ChimeActive), 0);
    chk("async_reset_muted", int'(Muted), 0);
    chk("async_reset_count", int'(BeepCount), 0);
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  // Monitor: one expected entry per clock edge while out of reset.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_L && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      popped++;
      chk("BuzzerOut", int'(BuzzerOut), e.buzz);
      chk("ChimeActive", int'(ChimeActive), e.active);
      chk("Muted", int'(Muted), e.muted);
      chk("BeepCount", int'(BeepCount), e.count);
    end
  end

  initial begin
    bit a;
    bit m;
    int hold;
    reset_L        = 1'b0;
    CarAlarmSignal = 1'b0;
    MuteButton     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_buzzer", int'(BuzzerOut), 0);
    chk("reset_muted", int'(Muted), 0);
    chk("reset_count", int'(BeepCount), 0);
    @(negedge clk);
    reset_L = 1'b1;

    // Glitch rejection, then hold high for a full auto-muted episode.
    cyc(1'b1, 1'b0, 3);
    cyc(1'b0, 1'b0, 1);
    cyc(1'b1, 1'b0, 3);
    settle();
    chk("glitch_no_buzz", int'(BuzzerOut), 0);
    cyc(1'b1, 1'b0, 1);
    settle();
    chk("first_beep_after_4", int'(BuzzerOut), 1);
    cyc(1'b1, 1'b0, 35);
    settle();
    chk("auto_mute_muted", int'(Muted), 1);
    chk("auto_mute_count", int'(BeepCount), MAXB);
    cyc(1'b0, 1'b0, 1);
    settle();
    chk("release_count_clear", int'(BeepCount), 0);
    chk("release_idle", int'(Muted), 0);

    // Early release during the second ON phase.
    cyc(1'b1, 1'b0, 10);
    cyc(1'b0, 1'b0, 10);
    settle();
    chk("early_release_idle", int'(ChimeActive), 0);

    // Mute pulse in the second ON phase, alarm held high.
    cyc(1'b1, 1'b0, 10);
    cyc(1'b1, 1'b1, 1);
    settle();
    chk("mute_buzz_off", int'(BuzzerOut), 0);
    chk("mute_count", int'(BeepCount), 1);
    cyc(1'b1, 1'b0, 10);
    settle();
    chk("mute_holds", int'(Muted), 1);
    cyc(1'b0, 1'b0, 2);

    // Mute ignored in IDLE, then normal debounce.
    cyc(1'b0, 1'b1, 3);
    cyc(1'b1, 1'b0, 20);
    cyc(1'b0, 1'b0, 8);

    // Reset in the middle of a beep.
    cyc(1'b1, 1'b0, 5);
    reset_pulse();
    cyc(1'b0, 1'b0, 5);

    // Randomized traffic.
    a    = 1'b0;
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        a    = ($urandom_range(0, 3) != 0);
        hold = int'($urandom_range(1, 20));
      end
      hold--;
      m = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) begin
        reset_pulse();
      end else begin
        cyc(a, m, 1);
      end
    end
    settle();
    chk("scoreboard_drained", popped, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
